// File: rtl/sar_pkg.sv
// Shared types and default parameter values for the SAR conversion sequencer.
package sar_pkg;

    // Sequencer phases: idle, sample/clear window, per-bit set+settle steps, result strobe.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    localparam int SAR_DEF_RES    = 10;
    localparam int SAR_DEF_SAMPLE = 4;
    localparam int SAR_DEF_SETTLE = 3;

endpackage

// File: rtl/sar_step_timer.sv
// Loadable down-counter with a last-cycle flag. Loading N gives a window of N+1 cycles;
// o_last is high in the final cycle of the window. Shared by the sample and settle windows.
module sar_step_timer
    import sar_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // Count down from the loaded value and park at zero until the next load.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sar_seq_ctrl.sv
// Synchronous sequencer for an asynchronous SAR register: clears it, walks one-hot active-low
// set pulses from the MSB line down to line 0, then captures the code. A shadow code built from
// the synchronised comparator is compared against the register at capture.
// Every output is a flop loaded from next-state decode, so outputs line up with the state and
// reach the asynchronous register glitch-free.
module sar_seq_ctrl
    import sar_pkg::*;
#(
    parameter int ADC_RESOLUTION = SAR_DEF_RES,
    parameter int SAMPLE_CYCLES  = SAR_DEF_SAMPLE,
    parameter int SETTLE_CYCLES  = SAR_DEF_SETTLE
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_comp,
    input  logic [ADC_RESOLUTION-1:0] i_a2d,
    output logic [ADC_RESOLUTION:0]   o_setn,
    output logic                      o_rstn,
    output logic                      o_sample,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [ADC_RESOLUTION-1:0] o_data,
    output logic                      o_mismatch
);

    localparam int RES = ADC_RESOLUTION;
    localparam int KW  = $clog2(RES + 1);
    localparam int SW  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int DW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TW  = (SW > DW) ? SW : DW;

    // The settle window must cover the two-flop comparator synchroniser.
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("sar_seq_ctrl: SETTLE_CYCLES must be >= 3");
    end
    if (SAMPLE_CYCLES < 1) begin : g_bad_sample
        $error("sar_seq_ctrl: SAMPLE_CYCLES must be >= 1");
    end

    sar_state_e      r_state;
    sar_state_e      w_state_next;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_next;
    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_val;
    logic            w_tmr_last;
    logic            w_shadow_we;
    logic            w_pulse;
    logic            r_sync1;
    logic            r_sync2;
    logic [RES-1:0]  r_shadow;
    logic [RES:0]    r_setn;
    logic            r_rstn;
    logic            r_sample;
    logic            r_busy;
    logic            r_valid;
    logic [RES-1:0]  r_data;
    logic            r_mismatch;

    sar_step_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_last     (w_tmr_last)
    );

    // Next-state, step-index and timer-load decode.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_shadow_we  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = SAMPLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TW'(SAMPLE_CYCLES - 1);
                end
            end
            SAMPLE: begin
                if (w_tmr_last) begin
                    w_state_next = STEP;
                    w_k_next     = KW'(RES);
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TW'(SETTLE_CYCLES);
                end
            end
            STEP: begin
                if (w_tmr_last) begin
                    if (r_k == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_shadow_we = 1'b1;
                        w_k_next    = r_k - KW'(1);
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(SETTLE_CYCLES);
                    end
                end
            end
            DONE: begin
                if (i_start) begin
                    w_state_next = SAMPLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TW'(SAMPLE_CYCLES - 1);
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A timer load that lands in STEP marks the first cycle of a step: the set-pulse cycle.
    assign w_pulse = w_tmr_load && (w_state_next == STEP);

    // State and step-index register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_comp;
            r_sync2 <= r_sync1;
        end
    end

    // Shadow code: cleared while sampling, bit k-1 taken on the last settle cycle of step k.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
        end else if (r_state == SAMPLE) begin
            r_shadow <= '0;
        end else if (w_shadow_we) begin
            for (int i = 0; i < RES; i++) begin
                if (r_k == KW'(i + 1)) begin
                    r_shadow[i] <= r_sync2;
                end
            end
        end
    end

    // Output flops, loaded from the decode of the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_setn     <= '1;
            r_rstn     <= 1'b1;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_mismatch <= 1'b0;
        end else begin
            for (int i = 0; i <= RES; i++) begin
                r_setn[i] <= !(w_pulse && (w_k_next == KW'(i)));
            end
            r_rstn   <= (w_state_next != SAMPLE);
            r_sample <= (w_state_next == SAMPLE);
            r_busy   <= (w_state_next == SAMPLE) || (w_state_next == STEP);
            r_valid  <= (w_state_next == DONE);
            if (w_state_next == DONE) begin
                r_data     <= i_a2d;
                r_mismatch <= (i_a2d != r_shadow);
            end
        end
    end

    assign o_setn     = r_setn;
    assign o_rstn     = r_rstn;
    assign o_sample   = r_sample;
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_mismatch = r_mismatch;

endmodule
